ps2_scan_decoder: RTL and testbench

Downstream stage of the PS/2 byte receiver. Consumes one received byte per strobe and assembles PS/2 Set-2 scan-code sequences (plain, E0-extended, F0-break, E0 F0 extended-break) into single key events. Tracks the currently held key, flags typematic repeats, and keeps the last two distinct make codes for the four-digit hex display.

---
 rtl/ps2_scan_decoder_pkg.sv | 33 +++
 rtl/ps2_scan_decoder_seq_timeout.sv | 36 +++
 rtl/ps2_scan_decoder.sv | 151 +++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_scan_decoder_pkg.sv
// ps2_scan_decoder_pkg: shared constants, FSM state type and byte
// classification helpers for the PS/2 Set-2 scan-code decoder.
package ps2_scan_decoder_pkg;

  localparam logic [7:0] PS2_EXT  = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PS2_BRK  = 8'hF0;  // break (release) prefix
  localparam logic [7:0] PS2_BAT  = 8'hAA;  // self-test passed
  localparam logic [7:0] PS2_ACK  = 8'hFA;  // command acknowledge
  localparam logic [7:0] PS2_RSND = 8'hFE;  // resend request
  localparam logic [7:0] PS2_OVR0 = 8'h00;  // keyboard buffer overrun
  localparam logic [7:0] PS2_OVR1 = 8'hFF;  // keyboard buffer overrun

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == PS2_OVR0) || (b == PS2_OVR1);
  endfunction

  // Keyboard status/response bytes; only meaningful at a sequence start.
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RSND);
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_seq_timeout.sv
// ps2_seq_timeout: inter-byte watchdog for multi-byte scan sequences.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : a sequence is in progress (decoder not idle)
//   clear      : a byte was accepted; restart the count
//   expire     : combinational; high during the cycle the count reaches
//                TIMEOUT_CYCLES-1 while running
module ps2_seq_timeout #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expire = run && (count == LAST);

  // Clearing on expiry leaves the counter at zero for the next sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: assembles PS/2 Set-2 byte sequences (plain, E0, F0,
// E0 F0) into single key events, tracks the held key, flags typematic
// repeats and keeps the last two distinct make codes for display.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   byte_in/byte_valid/byte_err : received byte, one-cycle strobe, frame error
//   evt_valid                   : one-cycle strobe, evt_* fields registered
//   evt_code/ext/break/repeat/err : event contents (evt_code=00 on error)
//   key_held, held_code, held_ext : currently / last held key
//   disp_code0, disp_code1      : newest and previous distinct make codes
// Handshake: byte_valid is a single-cycle strobe with no back-pressure; the
// decoder accepts every strobe except one that coincides with a timeout.
// evt_valid is likewise a one-cycle strobe with no ready.
module ps2_scan_decoder
  import ps2_scan_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_err,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_repeat,
  output logic       evt_err,
  output logic       key_held,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] disp_code0,
  output logic [7:0] disp_code1
);

  ps2_state_t state, next_state;
  logic       expire;
  logic       accept;
  logic       fire, f_err, f_ext, f_brk, f_rep, match;

  // A strobe landing on the expiry cycle is dropped.
  assign accept = byte_valid && !expire;

  ps2_seq_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state != ST_IDLE),
    .clear (accept),
    .expire(expire)
  );

  // Sequence decode: next state and the kind of event (if any) to emit.
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    f_err      = 1'b0;
    f_ext      = 1'b0;
    f_brk      = 1'b0;
    if (expire) begin
      next_state = ST_IDLE;
      fire       = 1'b1;
      f_err      = 1'b1;
    end else if (byte_valid) begin
      if (byte_err || is_overrun(byte_in)) begin
        next_state = ST_IDLE;
        fire       = 1'b1;
        f_err      = 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_in == PS2_EXT)      next_state = ST_EXT;
            else if (byte_in == PS2_BRK) next_state = ST_BRK;
            else if (!is_status(byte_in)) fire = 1'b1;
          end
          ST_EXT: begin
            if (byte_in == PS2_BRK) begin
              next_state = ST_EXT_BRK;
            end else if (byte_in != PS2_EXT) begin
              next_state = ST_IDLE;
              fire       = 1'b1;
              f_ext      = 1'b1;
            end
          end
          ST_BRK: begin
            next_state = ST_IDLE;
            fire       = 1'b1;
            f_err      = is_prefix(byte_in);
            f_brk      = !is_prefix(byte_in);
          end
          default: begin  // ST_EXT_BRK
            next_state = ST_IDLE;
            fire       = 1'b1;
            f_err      = is_prefix(byte_in);
            f_ext      = !is_prefix(byte_in);
            f_brk      = !is_prefix(byte_in);
          end
        endcase
      end
    end
  end

  assign match = (f_ext == held_ext) && (byte_in == held_code);
  assign f_rep = fire && !f_err && !f_brk && key_held && match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      evt_valid  <= 1'b0;
      evt_code   <= 8'h00;
      evt_ext    <= 1'b0;
      evt_break  <= 1'b0;
      evt_repeat <= 1'b0;
      evt_err    <= 1'b0;
      key_held   <= 1'b0;
      held_code  <= 8'h00;
      held_ext   <= 1'b0;
      disp_code0 <= 8'h00;
      disp_code1 <= 8'h00;
    end else begin
      state     <= next_state;
      evt_valid <= fire;
      if (fire) begin
        evt_code   <= f_err ? 8'h00 : byte_in;
        evt_ext    <= f_ext;
        evt_break  <= f_brk;
        evt_repeat <= f_rep;
        evt_err    <= f_err;
        if (!f_err) begin
          if (f_brk) begin
            // Only the release of the held key clears it; held_* stay for display.
            if (match) key_held <= 1'b0;
          end else if (!f_rep) begin
            key_held  <= 1'b1;
            held_code <= byte_in;
            held_ext  <= f_ext;
            if (byte_in != disp_code0) begin
              disp_code1 <= disp_code0;
              disp_code0 <= byte_in;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: table-driven directed vectors, hand-written timeout
// and reset sequences, then random byte streams checked against a
// sequence-level reference model through an expected-event queue.
module tb_ps2_scan_decoder;

  localparam int T     = 40;
  localparam int CNT_W = 6;
  localparam int EW    = 38;

  logic       clk;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_err;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_repeat, evt_err;
  logic       key_held;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] disp_code0, disp_code1;

  ps2_scan_decoder #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_repeat(evt_repeat),
    .evt_err   (evt_err),
    .key_held  (key_held),
    .held_code (held_code),
    .held_ext  (held_ext),
    .disp_code0(disp_code0),
    .disp_code1(disp_code1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // evt = {code, ext, brk, rep, err}; st = {held, hcode, hext, d0, d1}
  logic [11:0] act_evt;
  logic [25:0] act_st;
  logic [38:0] act_all;
  assign act_evt = {evt_code, evt_ext, evt_break, evt_repeat, evt_err};
  assign act_st  = {key_held, held_code, held_ext, disp_code0, disp_code1};
  assign act_all = {evt_valid, act_evt, act_st};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [7:0] b, input logic e);
    @(negedge clk);
    byte_in    = b;
    byte_err   = e;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic          mon_en = 1'b0;
  logic          m_ext, m_brk, m_held, m_hext;
  logic [7:0]    m_hcode, m_d0, m_d1;

  function automatic logic [EW-1:0] pack(input logic [7:0] c, input logic ext,
                                         input logic brk, input logic rep, input logic err);
    return {c, ext, brk, rep, err, m_held, m_hcode, m_hext, m_d0, m_d1};
  endfunction

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_held = 1'b0; m_hext = 1'b0;
    m_hcode = 8'h00; m_d0 = 8'h00; m_d1 = 8'h00;
  endtask

  task automatic model_err();
    exp_q.push_back(pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_key(input logic [7:0] b);
    logic rep;
    logic same;
    same = (m_hext == m_ext) && (m_hcode == b);
    rep  = 1'b0;
    if (m_brk) begin
      if (same) m_held = 1'b0;
    end else begin
      rep = m_held && same;
      if (!rep) begin
        m_held  = 1'b1;
        m_hcode = b;
        m_hext  = m_ext;
        if (b != m_d0) begin
          m_d1 = m_d0;
          m_d0 = b;
        end
      end
    end
    exp_q.push_back(pack(b, m_ext, m_brk, rep, 1'b0));
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  // Prefix flags say which of E0 / F0 have been collected so far.
  task automatic model_byte(input logic [7:0] b, input logic e);
    if (e || b == 8'h00 || b == 8'hFF) begin
      model_err();
    end else if (b == 8'hE0) begin
      if (m_brk) model_err();
      else m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      if (m_brk) model_err();
      else m_brk = 1'b1;
    end else if (!m_ext && !m_brk && (b == 8'hAA || b == 8'hFA || b == 8'hFE)) begin
      // status byte at sequence start: no event
    end else begin
      model_key(b);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && evt_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rand_evt: unexpected event got %h expected none", {act_evt, act_st});
      end else begin
        chk("rand_evt", {act_evt, act_st}, exp_q.pop_front());
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  b;
    logic        e;
    logic        ev;
    logic [11:0] evt;
    logic [25:0] st;
  } vec_t;

  vec_t tbl[27];

  initial begin
    int cyc;
    logic got;
    logic [7:0] codes[6];
    codes = '{8'h1C, 8'h32, 8'h75, 8'h6B, 8'h74, 8'h5A};

    tbl[0]  = '{8'h1C, 1'b0, 1'b1, {8'h1C, 4'b0000}, {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h00}};
    tbl[1]  = '{8'hF0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h00}};
    tbl[2]  = '{8'h1C, 1'b0, 1'b1, {8'h1C, 4'b0100}, {1'b0, 8'h1C, 1'b0, 8'h1C, 8'h00}};
    tbl[3]  = '{8'hE0, 1'b0, 1'b0, 12'h000,          {1'b0, 8'h1C, 1'b0, 8'h1C, 8'h00}};
    tbl[4]  = '{8'h75, 1'b0, 1'b1, {8'h75, 4'b1000}, {1'b1, 8'h75, 1'b1, 8'h75, 8'h1C}};
    tbl[5]  = '{8'hE0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h75, 1'b1, 8'h75, 8'h1C}};
    tbl[6]  = '{8'hF0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h75, 1'b1, 8'h75, 8'h1C}};
    tbl[7]  = '{8'h75, 1'b0, 1'b1, {8'h75, 4'b1100}, {1'b0, 8'h75, 1'b1, 8'h75, 8'h1C}};
    tbl[8]  = '{8'h1C, 1'b0, 1'b1, {8'h1C, 4'b0000}, {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h75}};
    tbl[9]  = '{8'h1C, 1'b0, 1'b1, {8'h1C, 4'b0010}, {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h75}};
    tbl[10] = '{8'h1C, 1'b0, 1'b1, {8'h1C, 4'b0010}, {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h75}};
    tbl[11] = '{8'hE0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h75}};
    tbl[12] = '{8'h5A, 1'b1, 1'b1, {8'h00, 4'b0001}, {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h75}};
    tbl[13] = '{8'hFF, 1'b0, 1'b1, {8'h00, 4'b0001}, {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h75}};
    tbl[14] = '{8'hAA, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h1C, 1'b0, 8'h1C, 8'h75}};
    tbl[15] = '{8'h32, 1'b0, 1'b1, {8'h32, 4'b0000}, {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C}};
    tbl[16] = '{8'hF0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C}};
    tbl[17] = '{8'h1C, 1'b0, 1'b1, {8'h1C, 4'b0100}, {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C}};
    tbl[18] = '{8'hF0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C}};
    tbl[19] = '{8'hE0, 1'b0, 1'b1, {8'h00, 4'b0001}, {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C}};
    tbl[20] = '{8'h32, 1'b0, 1'b1, {8'h32, 4'b0010}, {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C}};
    tbl[21] = '{8'hE0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C}};
    tbl[22] = '{8'hE0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C}};
    tbl[23] = '{8'h32, 1'b0, 1'b1, {8'h32, 4'b1000}, {1'b1, 8'h32, 1'b1, 8'h32, 8'h1C}};
    tbl[24] = '{8'hFA, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h32, 1'b1, 8'h32, 8'h1C}};
    tbl[25] = '{8'hF0, 1'b0, 1'b0, 12'h000,          {1'b1, 8'h32, 1'b1, 8'h32, 8'h1C}};
    tbl[26] = '{8'hFA, 1'b0, 1'b1, {8'hFA, 4'b0100}, {1'b1, 8'h32, 1'b1, 8'h32, 8'h1C}};

    rst_n      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", act_all, 39'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", act_all, 39'd0);

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].b, tbl[i].e);
      chk($sformatf("vec%0d_evt_valid", i), evt_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("vec%0d_evt", i), act_evt, tbl[i].evt);
      chk($sformatf("vec%0d_state", i), act_st, tbl[i].st);
    end

    // Timeout: F0 then silence; error event exactly T cycles after the F0 edge.
    drive(8'hF0, 1'b0);
    cyc = 0;
    got = 1'b0;
    while (cyc < 2 * T && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (evt_valid) got = 1'b1;
    end
    chk("timeout_seen", got, 1'b1);
    chk("timeout_cycle", cyc, T);
    chk("timeout_evt", act_evt, {8'h00, 4'b0001});
    @(posedge clk);
    #1;
    chk("timeout_single_strobe", evt_valid, 1'b0);
    drive(8'h32, 1'b0);
    chk("after_timeout_evt", {evt_valid, act_evt}, {1'b1, 8'h32, 4'b0000});
    chk("after_timeout_state", act_st, {1'b1, 8'h32, 1'b0, 8'h32, 8'h1C});

    // Byte arriving on the expiry cycle is dropped in favour of the timeout.
    drive(8'hF0, 1'b0);
    repeat (T - 1) @(posedge clk);
    drive(8'h1C, 1'b0);
    chk("collision_evt", {evt_valid, act_evt}, {1'b1, 8'h00, 4'b0001});
    drive(8'h2B, 1'b0);
    chk("collision_next_evt", {evt_valid, act_evt}, {1'b1, 8'h2B, 4'b0000});
    chk("collision_next_state", act_st, {1'b1, 8'h2B, 1'b0, 8'h2B, 8'h32});

    // Reset between E0 and 75.
    drive(8'hE0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midseq_reset_outputs", act_all, 39'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h75, 1'b0);
    chk("after_reset_evt", {evt_valid, act_evt}, {1'b1, 8'h75, 4'b0000});
    chk("after_reset_state", act_st, {1'b1, 8'h75, 1'b0, 8'h75, 8'h00});

    // Random streams against the reference model.
    do_reset();
    model_reset();
    mon_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] b;
      logic e;
      r = $urandom_range(0, 99);
      if (r < 15)      b = 8'hE0;
      else if (r < 30) b = 8'hF0;
      else if (r < 33) b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else if (r < 38) begin
        int s;
        s = $urandom_range(0, 2);
        b = (s == 0) ? 8'hAA : (s == 1) ? 8'hFA : 8'hFE;
      end else begin
        b = codes[$urandom_range(0, 5)];
      end
      e = ($urandom_range(0, 29) == 0);
      model_byte(b, e);
      drive(b, e);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
